// File: rtl/led_matrix_scanner_if.sv
// Scan-strobe, frame-write and shift-register-chain signals of the LED matrix scanner.
interface led_matrix_scanner_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int RW   = 3
);
    logic            tick_in;
    logic            wr_en;
    logic [RW-1:0]   wr_row;
    logic [COLS-1:0] wr_data;
    logic            swap_req;
    logic            swap_ack;
    logic            sr_data;
    logic            sr_clk;
    logic            sr_latch;
    logic [RW-1:0]   row_index;
    logic            frame_start;
    logic            overrun;

    // User logic / timer side
    modport master (
        output tick_in, wr_en, wr_row, wr_data, swap_req,
        input  swap_ack, sr_data, sr_clk, sr_latch, row_index, frame_start, overrun
    );

    // Scanner side
    modport slave (
        input  tick_in, wr_en, wr_row, wr_data, swap_req,
        output swap_ack, sr_data, sr_clk, sr_latch, row_index, frame_start, overrun
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for an 8x8 LED matrix behind a shift-register chain.
// Each tick_in transition shifts one {row_select, pixels} word out MSB first
// and latches it; a double-buffered frame store swaps only at row 0.
module led_matrix_scanner #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int SCK_DIV        = 4,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    led_matrix_scanner_if.slave  bus
);
    localparam int RW = $clog2(ROWS);
    localparam int WW = ROWS + COLS;
    localparam int BW = $clog2(WW);
    localparam logic [7:0] CNT_LAST = 8'(SCK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH_HI,
        S_LATCH_LO
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_tick_prev;
    logic            r_edge;
    logic [7:0]      r_cnt;
    logic [BW-1:0]   r_bit;
    logic [WW-1:0]   r_shreg;
    logic [RW-1:0]   r_next_row;
    logic [RW-1:0]   r_row_index;
    logic            r_front_sel;
    logic            r_swap_pend;
    logic            r_overrun;
    logic [COLS-1:0] r_buf [2][ROWS];

    logic            w_cnt_done;
    logic            w_frame_load;
    logic            w_do_swap;
    logic            w_load_sel;
    logic [ROWS-1:0] w_onehot;
    logic [ROWS-1:0] w_row_sel;
    logic            w_sr_data;
    logic            w_sr_clk;
    logic            w_sr_latch;
    logic            w_frame_start;
    logic            w_swap_ack;

    assign w_cnt_done   = (r_cnt == 8'd0);
    assign w_frame_load = (r_state == S_LOAD) && (r_next_row == '0);
    assign w_do_swap    = w_frame_load && r_swap_pend;
    // The row-0 word is read from the buffer that becomes front in this very cycle.
    assign w_load_sel   = r_front_sel ^ w_do_swap;
    assign w_onehot     = ROWS'(1) << (RW'(ROWS - 1) - r_next_row);
    assign w_row_sel    = (ROW_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;

    assign bus.sr_data     = w_sr_data;
    assign bus.sr_clk      = w_sr_clk;
    assign bus.sr_latch    = w_sr_latch;
    assign bus.frame_start = w_frame_start;
    assign bus.swap_ack    = w_swap_ack;
    assign bus.row_index   = r_row_index;
    assign bus.overrun     = r_overrun;

    // Register the strobe and flag any transition; reset preloads the level so release is edge-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_prev <= bus.tick_in;
            r_edge      <= 1'b0;
        end else begin
            r_tick_prev <= bus.tick_in;
            r_edge      <= bus.tick_in ^ r_tick_prev;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and output decode.
    always_comb begin
        w_state_next  = r_state;
        w_sr_data     = 1'b0;
        w_sr_clk      = 1'b0;
        w_sr_latch    = 1'b0;
        w_frame_start = 1'b0;
        w_swap_ack    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_edge) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                w_frame_start = w_frame_load;
                w_swap_ack    = w_do_swap;
                w_state_next  = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                w_sr_data = r_shreg[WW-1];
                if (w_cnt_done) w_state_next = S_SHIFT_HI;
            end
            S_SHIFT_HI: begin
                w_sr_data = r_shreg[WW-1];
                w_sr_clk  = 1'b1;
                if (w_cnt_done) w_state_next = (r_bit == '0) ? S_LATCH_HI : S_SHIFT_LO;
            end
            S_LATCH_HI: begin
                w_sr_latch = 1'b1;
                if (w_cnt_done) w_state_next = S_LATCH_LO;
            end
            S_LATCH_LO: begin
                if (w_cnt_done) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shift datapath, phase counter, row pointers, swap bookkeeping and overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 8'd0;
            r_bit       <= '0;
            r_shreg     <= '0;
            r_next_row  <= '0;
            r_row_index <= '0;
            r_front_sel <= 1'b0;
            r_swap_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (r_edge && (r_state != S_IDLE)) r_overrun <= 1'b1;

            // A request coinciding with the swap is absorbed by it.
            if (w_do_swap) begin
                r_front_sel <= ~r_front_sel;
                r_swap_pend <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pend <= 1'b1;
            end

            case (r_state)
                S_LOAD: begin
                    r_shreg <= {w_row_sel, r_buf[w_load_sel][r_next_row]};
                    r_bit   <= BW'(WW - 1);
                    r_cnt   <= CNT_LAST;
                end
                S_SHIFT_LO, S_LATCH_HI: begin
                    r_cnt <= w_cnt_done ? CNT_LAST : r_cnt - 8'd1;
                end
                S_SHIFT_HI: begin
                    if (w_cnt_done) begin
                        r_cnt <= CNT_LAST;
                        if (r_bit != '0) begin
                            r_bit   <= r_bit - 1'b1;
                            r_shreg <= {r_shreg[WW-2:0], 1'b0};
                        end else begin
                            r_row_index <= r_next_row;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_LATCH_LO: begin
                    if (w_cnt_done) begin
                        r_next_row <= (r_next_row == RW'(ROWS - 1)) ? '0 : r_next_row + 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame store: writes always go to the back buffer as selected before any same-cycle swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                r_buf[0][r] <= '0;
                r_buf[1][r] <= '0;
            end
        end else if (bus.wr_en && (int'(bus.wr_row) < ROWS)) begin
            r_buf[~r_front_sel][bus.wr_row] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: scoreboard of expected shifted words.
module tb_led_matrix_scanner;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    led_matrix_scanner_if #(.ROWS(8), .COLS(8), .RW(3)) bus ();

    led_matrix_scanner #(
        .ROWS(8), .COLS(8), .SCK_DIV(4), .ROW_ACTIVE_LOW(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  row;
        logic [15:0] word;
    } exp_t;

    // Active-low row select bytes, row 0 at the MSB.
    localparam logic [7:0] ROW_SEL [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    exp_t       sb_q [$];
    int         n_cmp = 0;
    int         n_err = 0;

    logic [7:0] mdl_buf [2][8];
    logic       mdl_sel;
    logic       mdl_pend;
    logic [2:0] mdl_next;

    int          cyc = 0;
    int          n_sck = 0;
    int          n_latch = 0;
    int          n_fs = 0;
    int          n_ack = 0;
    int          fs_cyc = 0;
    logic        fs_seen = 1'b0;
    logic [15:0] mon_word = '0;
    int          mon_bits = 0;
    int          lat_w = 0;
    logic        p_sck = 1'b0;
    logic        p_lat = 1'b0;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] out_vec();
        return {bus.sr_data, bus.sr_clk, bus.sr_latch, bus.swap_ack,
                bus.frame_start, bus.overrun, bus.row_index};
    endfunction

    // Output monitor: rebuilds each shifted word and compares it against the scoreboard at latch time.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_bits = 0;
            mon_word = '0;
            lat_w    = 0;
            p_sck    = 1'b0;
            p_lat    = 1'b0;
            fs_seen  = 1'b0;
        end else begin
            if (bus.frame_start) begin
                n_fs++;
                fs_cyc  = cyc;
                fs_seen = 1'b1;
            end
            if (bus.swap_ack) begin
                n_ack++;
                check("ack_with_frame_start", bus.frame_start, 1);
            end
            if (bus.sr_clk && !p_sck) begin
                mon_word = {mon_word[14:0], bus.sr_data};
                mon_bits++;
                n_sck++;
            end
            if (bus.sr_latch && !p_lat) begin
                n_latch++;
                check("latch_expected", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("word", mon_word, mon_e.word);
                    check("row_index", bus.row_index, mon_e.row);
                end
                check("shift_count", mon_bits, 16);
                mon_bits = 0;
                mon_word = '0;
                lat_w    = 0;
            end
            if (bus.sr_latch) lat_w++;
            if (!bus.sr_latch && p_lat) begin
                check("latch_width", lat_w, 4);
                if (fs_seen) check("load_to_latch_end", cyc - fs_cyc, 133);
                fs_seen = 1'b0;
            end
            p_sck = bus.sr_clk;
            p_lat = bus.sr_latch;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < 8; r++) mdl_buf[b][r] = '0;
        mdl_sel  = 1'b0;
        mdl_pend = 1'b0;
        mdl_next = '0;
    endtask

    task automatic write_row(input logic [2:0] row, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_row  = row;
        bus.wr_data = data;
        mdl_buf[~mdl_sel][row] = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic swap_pulse();
        bus.swap_req = 1'b1;
        mdl_pend     = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;
    endtask

    // Toggle the strobe and queue the word the next row must produce.
    task automatic do_tick();
        exp_t e;
        if (mdl_next == 3'd0 && mdl_pend) begin
            mdl_sel  = ~mdl_sel;
            mdl_pend = 1'b0;
        end
        e.row  = mdl_next;
        e.word = {ROW_SEL[mdl_next], mdl_buf[mdl_sel][mdl_next]};
        sb_q.push_back(e);
        mdl_next = (mdl_next == 3'd7) ? 3'd0 : mdl_next + 3'd1;
        bus.tick_in = ~bus.tick_in;
    endtask

    initial begin
        int   lat0;
        int   ack0;
        int   rises;
        logic prev;
        logic found;

        rst          = 1'b1;
        bus.tick_in  = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_row   = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b0;
        model_clear();

        // Reset state, then quiet release with tick_in held high.
        wait_cycles(3);
        check("reset_outputs", out_vec(), 0);
        rst = 1'b0;
        wait_cycles(50);
        check("idle_no_sck", n_sck, 0);
        check("idle_no_latch", n_latch, 0);
        check("idle_no_frame_start", n_fs, 0);
        check("idle_row_index", bus.row_index, 0);

        // First frame with a swap: row 0 = A5 gives 16'h7FA5.
        write_row(3'd0, 8'hA5);
        swap_pulse();
        do_tick();
        wait_cycles(200);
        check("first_frame_start", n_fs, 1);
        check("first_swap_ack", n_ack, 1);
        check("first_latch", n_latch, 1);
        check("first_overrun", bus.overrun, 0);

        // Full frame at the nominal tick spacing, wrapping back to row 0.
        wait_cycles(6051);
        for (int k = 0; k < 8; k++) begin
            do_tick();
            wait_cycles(6251);
        end
        check("frame2_frame_start", n_fs, 2);
        check("frame2_latches", n_latch, 9);
        check("frame2_overrun", bus.overrun, 0);
        check("frame2_row_index", bus.row_index, 0);

        // Overrun: second edge 20 cycles into row 1 is dropped.
        do_tick();
        wait_cycles(20);
        bus.tick_in = ~bus.tick_in;
        wait_cycles(300);
        check("overrun_set", bus.overrun, 1);
        check("overrun_one_row", n_latch, 10);
        check("overrun_no_frame", n_fs, 2);
        check("overrun_queue_drained", sb_q.size(), 0);

        // Rows 2..7 with three swap requests pending before the boundary.
        ack0 = n_ack;
        for (int k = 0; k < 6; k++) begin
            do_tick();
            wait_cycles(100);
            if (k < 3) swap_pulse();
            wait_cycles(100);
        end
        // Row 0 with swap; write row 3 in the swap cycle itself.
        do_tick();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_start) found = 1'b1;
        end
        check("swap_frame_start_seen", found, 1);
        bus.wr_en   = 1'b1;
        bus.wr_row  = 3'd3;
        bus.wr_data = 8'hFF;
        mdl_buf[mdl_sel][3] = 8'hFF;  // pre-swap back buffer is the new front
        @(negedge clk);
        bus.wr_en = 1'b0;
        wait_cycles(200);
        check("collapsed_swap_ack", n_ack - ack0, 1);
        for (int k = 0; k < 3; k++) begin
            do_tick();
            wait_cycles(200);
        end
        check("row3_queue_drained", sb_q.size(), 0);
        check("row3_row_index", bus.row_index, 3);

        // Reset during bit 7 of the row-4 shift.
        do_tick();
        rises = 0;
        prev  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (bus.sr_clk && !prev) rises++;
            prev = bus.sr_clk;
            if (rises == 8 && !bus.sr_clk) found = 1'b1;
        end
        check("reached_bit7", found, 1);
        lat0 = n_latch;
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs", out_vec(), 0);
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        wait_cycles(2);
        model_clear();
        rst = 1'b0;
        wait_cycles(50);
        check("abort_no_latch", n_latch, lat0);
        do_tick();
        wait_cycles(200);
        check("post_reset_latch", n_latch, lat0 + 1);
        check("post_reset_queue_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
